// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if -- bundle between decode/writeback/dispatch logic and the
// dispatch queue.
//   master : decode + writeback side. Drives flush, the enqueue request, the
//            writeback broadcast and rs_full. Sees in_ready, the dispatched
//            entry and count.
//   slave  : the dispatch queue itself.
interface dispatch_queue_if #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int EX_UNITS = 4,
    parameter int OP_W     = 5,
    parameter int EXU_W    = 3
);
    logic                      flush;

    logic                      in_valid;
    logic                      in_ready;
    logic [EXU_W-1:0]          in_ex_unit;
    logic [OP_W-1:0]           in_op;
    logic [2:0]                in_width;
    logic [TAG_W-1:0]          in_tag1, in_tag2;
    logic [DATA_W-1:0]         in_val1, in_val2;
    logic [TAG_W-1:0]          in_target;
    logic [DATA_W-1:0]         in_pc, in_offset;

    logic                      wb_valid;
    logic [TAG_W-1:0]          wb_tag;
    logic [DATA_W-1:0]         wb_data;

    logic [EX_UNITS-1:0]       rs_full;

    logic                      out_valid;
    logic [EXU_W-1:0]          out_ex_unit;
    logic [OP_W-1:0]           out_op;
    logic [2:0]                out_width;
    logic [TAG_W-1:0]          out_tag1, out_tag2;
    logic [DATA_W-1:0]         out_val1, out_val2;
    logic [TAG_W-1:0]          out_target;
    logic [DATA_W-1:0]         out_pc, out_offset;

    logic [$clog2(DEPTH):0]    count;

    modport master (
        output flush, in_valid, in_ex_unit, in_op, in_width, in_tag1, in_tag2,
               in_val1, in_val2, in_target, in_pc, in_offset,
               wb_valid, wb_tag, wb_data, rs_full,
        input  in_ready, out_valid, out_ex_unit, out_op, out_width, out_tag1,
               out_tag2, out_val1, out_val2, out_target, out_pc, out_offset, count
    );

    modport slave (
        input  flush, in_valid, in_ex_unit, in_op, in_width, in_tag1, in_tag2,
               in_val1, in_val2, in_target, in_pc, in_offset,
               wb_valid, wb_tag, wb_data, rs_full,
        output in_ready, out_valid, out_ex_unit, out_op, out_width, out_tag1,
               out_tag2, out_val1, out_val2, out_target, out_pc, out_offset, count
    );
endinterface

// File: rtl/dispatch_queue.sv
// dispatch_queue -- in-order circular FIFO between decode and the
// reservation stations. Entries snoop the writeback bus while they wait, and
// the head entry sees a same-cycle writeback through an output bypass.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears pointers, count, entries)
//   bus    dispatch_queue_if.slave: flush, enqueue handshake (in_*),
//          writeback broadcast (wb_*), rs_full, dispatched entry (out_*),
//          count of occupied entries
module dispatch_queue #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int EX_UNITS = 4,
    parameter int OP_W     = 5,
    parameter int EXU_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    dispatch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [EXU_W-1:0]  ex_unit;
        logic [OP_W-1:0]   op;
        logic [2:0]        width;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [TAG_W-1:0]  target;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] offset;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [AW:0]     count;
    entry_t          in_e, head_e;
    logic            head_blocked;
    logic            enq, enq_write, deq;

    // Resolve pending sources against the writeback bus. Tag 0 means the
    // operand is already present, so a zero wb_tag never matches.
    function automatic entry_t snoop(entry_t e, logic v, logic [TAG_W-1:0] t,
                                     logic [DATA_W-1:0] d);
        entry_t r;
        r = e;
        if (v && t != '0 && e.tag1 == t) begin
            r.val1 = d;
            r.tag1 = '0;
        end
        if (v && t != '0 && e.tag2 == t) begin
            r.val2 = d;
            r.tag2 = '0;
        end
        return r;
    endfunction

    always_comb begin
        in_e         = '0;
        in_e.ex_unit = bus.in_ex_unit;
        in_e.op      = bus.in_op;
        in_e.width   = bus.in_width;
        in_e.tag1    = bus.in_tag1;
        in_e.tag2    = bus.in_tag2;
        in_e.val1    = bus.in_val1;
        in_e.val2    = bus.in_val2;
        in_e.target  = bus.in_target;
        in_e.pc      = bus.in_pc;
        in_e.offset  = bus.in_offset;
    end

    // Unit codes beyond EX_UNITS have no station to be full, so they never block.
    always_comb begin
        head_blocked = 1'b0;
        for (int u = 0; u < EX_UNITS; u++)
            if (mem[head].ex_unit == EXU_W'(u))
                head_blocked = bus.rs_full[u];
    end

    assign head_e        = snoop(mem[head], bus.wb_valid, bus.wb_tag, bus.wb_data);

    assign bus.in_ready  = (count != (AW+1)'(DEPTH)) && !bus.flush;
    assign bus.out_valid = (count != '0) && !head_blocked && !bus.flush;
    assign bus.count     = count;

    assign enq       = bus.in_valid && bus.in_ready;
    // Unit 0 is the error unit: handshake completes but nothing is stored.
    assign enq_write = enq && (bus.in_ex_unit != '0);
    assign deq       = bus.out_valid;

    assign bus.out_ex_unit = head_e.ex_unit;
    assign bus.out_op      = head_e.op;
    assign bus.out_width   = head_e.width;
    assign bus.out_tag1    = head_e.tag1;
    assign bus.out_tag2    = head_e.tag2;
    assign bus.out_val1    = head_e.val1;
    assign bus.out_val2    = head_e.val2;
    assign bus.out_target  = head_e.target;
    assign bus.out_pc      = head_e.pc;
    assign bus.out_offset  = head_e.offset;

    // Pointers and occupancy. flush wins over everything; in_ready and
    // out_valid are already low during flush, so enq/deq are quiet then too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_write) tail <= tail + 1'b1;
            if (deq)       head <= head + 1'b1;
            case ({enq_write, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage. Every slot snoops each cycle; empty slots are harmless
    // since they are overwritten on enqueue and flush just drops the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq_write && tail == AW'(i))
                    mem[i] <= snoop(in_e, bus.wb_valid, bus.wb_tag, bus.wb_data);
                else
                    mem[i] <= snoop(mem[i], bus.wb_valid, bus.wb_tag, bus.wb_data);
            end
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
    localparam int DEPTH = 4, DATA_W = 32, TAG_W = 4, EX_UNITS = 4, OP_W = 5, EXU_W = 3;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    dispatch_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
                        .EX_UNITS(EX_UNITS), .OP_W(OP_W), .EXU_W(EXU_W)) bus();

    dispatch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
                     .EX_UNITS(EX_UNITS), .OP_W(OP_W), .EXU_W(EXU_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model: an in-order list of waiting instructions.
    typedef struct {
        logic [EXU_W-1:0]  unit;
        logic [OP_W-1:0]   op;
        logic [2:0]        width;
        logic [TAG_W-1:0]  tag1, tag2;
        logic [DATA_W-1:0] val1, val2;
        logic [TAG_W-1:0]  target;
        logic [DATA_W-1:0] pc, offset;
    } ent_t;

    ent_t q[$];

    function automatic ent_t snp(ent_t e);
        ent_t r = e;
        if (bus.wb_valid && bus.wb_tag != 0) begin
            if (e.tag1 == bus.wb_tag) begin r.tag1 = 0; r.val1 = bus.wb_data; end
            if (e.tag2 == bus.wb_tag) begin r.tag2 = 0; r.val2 = bus.wb_data; end
        end
        return r;
    endfunction

    function automatic ent_t cur_in();
        ent_t e;
        e.unit = bus.in_ex_unit; e.op = bus.in_op; e.width = bus.in_width;
        e.tag1 = bus.in_tag1; e.tag2 = bus.in_tag2;
        e.val1 = bus.in_val1; e.val2 = bus.in_val2;
        e.target = bus.in_target; e.pc = bus.in_pc; e.offset = bus.in_offset;
        return e;
    endfunction

    function automatic bit blk(logic [EXU_W-1:0] u);
        if (int'(u) < EX_UNITS) return bus.rs_full[u];
        return 1'b0;
    endfunction

    function automatic bit exp_valid();
        return (q.size() != 0) && !blk(q[0].unit) && !bus.flush;
    endfunction

    // Advance one clock, updating the model from the inputs held this cycle.
    task automatic tick();
        int sz;
        bit ov;
        sz = q.size();
        ov = exp_valid();
        if (bus.flush) q.delete();
        else begin
            if (ov) void'(q.pop_front());
            foreach (q[i]) q[i] = snp(q[i]);
            if (bus.in_valid && sz < DEPTH && bus.in_ex_unit != 0) q.push_back(snp(cur_in()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic [EXU_W-1:0] unit, input logic [TAG_W-1:0] t1,
                            input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v1,
                            input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] tgt);
        bus.in_ex_unit = unit;
        bus.in_op      = OP_W'($urandom);
        bus.in_width   = 3'($urandom);
        bus.in_tag1    = t1;
        bus.in_tag2    = t2;
        bus.in_val1    = v1;
        bus.in_val2    = v2;
        bus.in_target  = tgt;
        bus.in_pc      = $urandom;
        bus.in_offset  = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.flush = 0; bus.in_valid = 0; bus.wb_valid = 0; bus.wb_tag = 0; bus.wb_data = 0;
        bus.rs_full = 0;
        drive_in(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        checks++; if ({bus.out_val1, bus.out_val2, bus.out_pc, bus.out_offset, bus.out_target} !== '0) begin
            failures++; $display("FAIL reset_out_data got=%h want=0", {bus.out_val1, bus.out_val2, bus.out_pc, bus.out_offset, bus.out_target}); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        bus.rs_full = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            drive_in(1, 0, 0, $urandom, $urandom, TAG_W'(k));
            bus.in_valid = 1;
            tick();
        end
        bus.in_valid = 0;
        #1;
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d want=4", bus.count); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b want=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fill_blocked got=%b want=0", bus.out_valid); end
        drive_in(1, 0, 0, 0, 0, 9);
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        #1;
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_reject_count got=%0d want=4", bus.count); end
        bus.rs_full = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_target !== TAG_W'(k)) begin
                failures++; $display("FAIL drain_order valid=%b target=%0d want target=%0d", bus.out_valid, bus.out_target, k); end
            tick();
        end
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL drain_empty count=%0d valid=%b want 0/0", bus.count, bus.out_valid); end
    endtask

    task automatic test_snoop();
        bus.rs_full = 4'b0100;
        drive_in(2, 3, 0, 32'h1111, 32'h2222, 7);
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        bus.wb_valid = 1; bus.wb_tag = 3; bus.wb_data = 32'hDEAD;
        #1;
        checks++; if (bus.out_val1 !== 32'hDEAD || bus.out_tag1 !== 4'd0) begin
            failures++; $display("FAIL snoop_bypass val1=%h tag1=%0d want DEAD/0", bus.out_val1, bus.out_tag1); end
        tick();
        bus.wb_valid = 0;
        #1;
        checks++; if (bus.out_val1 !== 32'hDEAD || bus.out_tag1 !== 4'd0) begin
            failures++; $display("FAIL snoop_capture val1=%h tag1=%0d want DEAD/0", bus.out_val1, bus.out_tag1); end
        bus.wb_valid = 1; bus.wb_tag = 0; bus.wb_data = 32'hBEEF;
        #1;
        checks++; if (bus.out_val2 !== 32'h2222 || bus.out_val1 !== 32'hDEAD) begin
            failures++; $display("FAIL snoop_tag0 val1=%h val2=%h want DEAD/2222", bus.out_val1, bus.out_val2); end
        tick();
        bus.wb_valid = 0;
        bus.rs_full = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_val2 !== 32'h2222) begin
            failures++; $display("FAIL snoop_release valid=%b val2=%h want 1/2222", bus.out_valid, bus.out_val2); end
        tick();
    endtask

    task automatic test_enq_snoop();
        bus.rs_full = 0;
        drive_in(3, 0, 5, 32'h0, 32'h7, 2);
        bus.in_valid = 1;
        bus.wb_valid = 1; bus.wb_tag = 5; bus.wb_data = 32'h42;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL enq_no_bypass valid=%b want 0", bus.out_valid); end
        tick();
        bus.in_valid = 0; bus.wb_valid = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag2 !== 4'd0 || bus.out_val2 !== 32'h42) begin
            failures++; $display("FAIL enq_snoop valid=%b tag2=%0d val2=%h want 1/0/42", bus.out_valid, bus.out_tag2, bus.out_val2); end
        tick();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL enq_snoop_drain count=%0d want 0", bus.count); end
    endtask

    task automatic test_wrap();
        bus.rs_full = 0;
        drive_in(1, 0, 0, 32'hA0, 32'hB0, 1);
        bus.in_valid = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            drive_in(1, 0, 0, 32'hA1 + i, 32'hB1 + i, TAG_W'(i + 2));
            #1;
            checks++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_target !== TAG_W'(i + 1)) begin
                failures++; $display("FAIL wrap_%0d count=%0d valid=%b target=%0d want 1/1/%0d", i, bus.count, bus.out_valid, bus.out_target, i + 1); end
            tick();
        end
        bus.in_valid = 0;
        #1;
        checks++; if (bus.count !== 3'd1 || bus.out_target !== 4'd11 || bus.out_val1 !== 32'hAA) begin
            failures++; $display("FAIL wrap_last count=%0d target=%0d val1=%h want 1/11/aa", bus.count, bus.out_target, bus.out_val1); end
        tick();
    endtask

    task automatic test_flush();
        bus.rs_full = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            drive_in(1, 0, 0, $urandom, $urandom, TAG_W'(k + 4));
            bus.in_valid = 1;
            tick();
        end
        drive_in(1, 0, 0, 0, 0, 15);
        bus.rs_full = 0;
        bus.flush = 1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_comb valid=%b ready=%b want 0/0", bus.out_valid, bus.in_ready); end
        tick();
        bus.flush = 0; bus.in_valid = 0;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_clear count=%0d valid=%b want 0/0", bus.count, bus.out_valid); end
        bus.rs_full = 4'b0010;
        drive_in(1, 0, 0, 1, 2, 3);
        bus.in_valid = 1;
        tick();
        drive_in(0, 0, 0, 1, 2, 6);
        tick();
        bus.in_valid = 0;
        #1;
        checks++; if (bus.count !== 3'd1 || bus.out_target !== 4'd3) begin
            failures++; $display("FAIL unit0_drop count=%0d target=%0d want 1/3", bus.count, bus.out_target); end
        bus.flush = 1;
        tick();
        bus.flush = 0;
        bus.rs_full = 0;
    endtask

    task automatic test_reset_mid();
        bus.rs_full = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            drive_in(1, 0, 0, $urandom, $urandom, TAG_W'(k + 3));
            bus.in_valid = 1;
            tick();
        end
        bus.in_valid = 0;
        bus.rs_full = 0;
        #1;
        checks++; if (bus.count !== 3'd2 || bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre count=%0d valid=%b want 2/1", bus.count, bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.out_target !== 4'd0) begin
            failures++; $display("FAIL rstmid_async valid=%b count=%0d target=%0d want 0/0/0", bus.out_valid, bus.count, bus.out_target); end
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.count !== 3'd0) begin
            failures++; $display("FAIL rstmid_release ready=%b count=%0d want 1/0", bus.in_ready, bus.count); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        ent_t ef;
        for (int n = 0; n < 600; n++) begin
            drive_in(($urandom % 8 == 0) ? 3'd0 : 3'($urandom_range(1, 3)),
                     4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                     $urandom, $urandom, 4'($urandom));
            bus.in_valid = ($urandom % 3) != 0;
            bus.wb_valid = $urandom % 2;
            bus.wb_tag   = 4'($urandom_range(0, 7));
            bus.wb_data  = $urandom;
            bus.rs_full  = 4'($urandom);
            bus.flush    = ($urandom % 20) == 0;
            #1;
            checks++; if (bus.out_valid !== exp_valid()) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", n, bus.out_valid, exp_valid()); end
            checks++; if (bus.count !== 3'(q.size())) begin
                failures++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", n, bus.count, q.size()); end
            checks++; if (bus.in_ready !== (q.size() != DEPTH && !bus.flush)) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b size=%0d", n, bus.in_ready, q.size()); end
            if (q.size() != 0) begin
                ef = snp(q[0]);
                checks++;
                if ({bus.out_ex_unit, bus.out_op, bus.out_width, bus.out_tag1, bus.out_tag2, bus.out_val1,
                     bus.out_val2, bus.out_target, bus.out_pc, bus.out_offset} !==
                    {ef.unit, ef.op, ef.width, ef.tag1, ef.tag2, ef.val1, ef.val2, ef.target, ef.pc, ef.offset}) begin
                    failures++;
                    $display("FAIL rnd_head cyc=%0d got=%h want=%h", n,
                        {bus.out_ex_unit, bus.out_op, bus.out_width, bus.out_tag1, bus.out_tag2, bus.out_val1,
                         bus.out_val2, bus.out_target, bus.out_pc, bus.out_offset},
                        {ef.unit, ef.op, ef.width, ef.tag1, ef.tag2, ef.val1, ef.val2, ef.target, ef.pc, ef.offset});
                end
            end
            tick();
        end
        bus.in_valid = 0; bus.wb_valid = 0; bus.flush = 0; bus.rs_full = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_snoop();
        test_enq_snoop();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
